// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encodings, BCD limits and timer defaults
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPIRED  = 2'd3
    } run_state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] tenths;
    } bcd_time_t;

    localparam logic [3:0] BCD_MAX_NINE = 4'd9;
    localparam logic [3:0] BCD_MAX_FIVE = 4'd5;

    localparam bcd_time_t TIME_EXPIRY = 20'h59599;

    localparam int CLK_HZ_DEFAULT  = 100_000_000;
    localparam int TICK_HZ_DEFAULT = 10;

    // Ripple increment of MM:SS.t; the caller holds at TIME_EXPIRY so min_tens never wraps in use.
    function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.tenths != BCD_MAX_NINE) begin
            r.tenths = t.tenths + 4'd1;
        end else begin
            r.tenths = 4'd0;
            if (t.sec_ones != BCD_MAX_NINE) begin
                r.sec_ones = t.sec_ones + 4'd1;
            end else begin
                r.sec_ones = 4'd0;
                if (t.sec_tens != BCD_MAX_FIVE) begin
                    r.sec_tens = t.sec_tens + 4'd1;
                end else begin
                    r.sec_tens = 4'd0;
                    if (t.min_ones != BCD_MAX_NINE) begin
                        r.min_ones = t.min_ones + 4'd1;
                    end else begin
                        r.min_ones = 4'd0;
                        r.min_tens = (t.min_tens != BCD_MAX_FIVE) ? t.min_tens + 4'd1 : 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_run_controller_if.sv
// rtl/timer_run_controller_if.sv - button/status bundle; Lap_Btn exists only with TIMER_LAP_HOLD_EN
interface timer_run_controller_if;

    logic       Start_Btn;
    logic       Stop_Btn;
    logic       Clear_Btn;
`ifdef TIMER_LAP_HOLD_EN
    logic       Lap_Btn;
`endif
    logic       Div_En;
    logic       Tick;
    logic [3:0] Tenths;
    logic [3:0] Sec_Ones;
    logic [3:0] Sec_Tens;
    logic [3:0] Min_Ones;
    logic [3:0] Min_Tens;
    logic [1:0] State;
    logic       Expired;

    modport master (
`ifdef TIMER_LAP_HOLD_EN
        output Lap_Btn,
`endif
        output Start_Btn, Stop_Btn, Clear_Btn,
        input  Div_En, Tick, Tenths, Sec_Ones, Sec_Tens, Min_Ones, Min_Tens, State, Expired
    );

    modport slave (
`ifdef TIMER_LAP_HOLD_EN
        input  Lap_Btn,
`endif
        input  Start_Btn, Stop_Btn, Clear_Btn,
        output Div_En, Tick, Tenths, Sec_Ones, Sec_Tens, Min_Ones, Min_Tens, State, Expired
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - phase-preserving divider producing a registered one-cycle tick
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic Clk_In,
    input  logic Rst,
    input  logic Run,
    input  logic Zero,
    output logic Tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic          tick_q;

    // Count holds while Run is low, so a pause resumes at the same phase.
    always_ff @(posedge Clk_In) begin
        if (Rst || Zero) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (Run) begin
                if (count_q == LAST) begin
                    count_q <= '0;
                    tick_q  <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign Tick = tick_q;

endmodule

// File: rtl/timer_run_controller.sv
// rtl/timer_run_controller.sv - run/pause/clear FSM and BCD MM:SS.t counter; lap hold under TIMER_LAP_HOLD_EN
module timer_run_controller
    import timer_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int TICK_HZ  = TICK_HZ_DEFAULT,
    parameter int TICK_DIV = CLK_HZ / TICK_HZ
) (
    input  logic                    Clk_In,
    input  logic                    Rst,
    timer_run_controller_if.slave   Ctl
);

    run_state_t state_q, state_d;
    bcd_time_t  count_q, count_d, display;
    logic       div_en_q;
    logic       tick;
    logic       clear_hit;
    logic       expiring;
    logic       presc_run;

    assign expiring = tick && (count_q == TIME_EXPIRY);

`ifdef TIMER_LAP_HOLD_EN
    logic      lap_hit;
    logic      lap_q;
    bcd_time_t snap_q;
`endif

    // Only the highest-priority pulse present is considered (Clear > Stop > Lap > Start).
    always_comb begin
        state_d   = state_q;
        clear_hit = 1'b0;
`ifdef TIMER_LAP_HOLD_EN
        lap_hit   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!Ctl.Clear_Btn && !Ctl.Stop_Btn && Ctl.Start_Btn)
                    state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (Ctl.Clear_Btn) begin
                    state_d   = ST_IDLE;
                    clear_hit = 1'b1;
                end else if (expiring) begin
                    state_d = ST_EXPIRED;
                end else if (Ctl.Stop_Btn) begin
                    state_d = ST_PAUSED;
                end
`ifdef TIMER_LAP_HOLD_EN
                else if (Ctl.Lap_Btn) begin
                    lap_hit = 1'b1;
                end
`endif
            end
            ST_PAUSED: begin
                if (Ctl.Clear_Btn) begin
                    state_d   = ST_IDLE;
                    clear_hit = 1'b1;
                end else if (!Ctl.Stop_Btn && Ctl.Start_Btn) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_EXPIRED: begin
                if (Ctl.Clear_Btn) begin
                    state_d   = ST_IDLE;
                    clear_hit = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (clear_hit)
            count_d = '0;
        else if (state_q == ST_RUNNING && tick && !expiring)
            count_d = bcd_time_inc(count_q);
    end

    // Prescaler freezes on the edge that leaves RUNNING, so a stop on a tick leaves it at 0.
    assign presc_run = (state_q == ST_RUNNING) && (state_d == ST_RUNNING);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clk_In (Clk_In),
        .Rst    (Rst),
        .Run    (presc_run),
        .Zero   (clear_hit),
        .Tick   (tick)
    );

    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            div_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            div_en_q <= (state_d == ST_RUNNING);
        end
    end

`ifdef TIMER_LAP_HOLD_EN
    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else if (clear_hit || state_d == ST_EXPIRED) begin
            lap_q <= 1'b0;
        end else if (lap_hit) begin
            lap_q <= ~lap_q;
            if (!lap_q)
                snap_q <= count_q;
        end
    end

    assign display = lap_q ? snap_q : count_q;
`else
    assign display = count_q;
`endif

    assign Ctl.State    = state_q;
    assign Ctl.Div_En   = div_en_q;
    assign Ctl.Expired  = (state_q == ST_EXPIRED);
    assign Ctl.Tick     = tick;
    assign Ctl.Tenths   = display.tenths;
    assign Ctl.Sec_Ones = display.sec_ones;
    assign Ctl.Sec_Tens = display.sec_tens;
    assign Ctl.Min_Ones = display.min_ones;
    assign Ctl.Min_Tens = display.min_tens;

endmodule

// File: doc/timer_run_controller.md
Name: timer_run_controller

Overview:
- Run/pause/clear sequencer for the 60-minute decimal timer clock.
- Turns debounced user pulses into a four-state run FSM.
- Generates a phase-preserving tick enable at TICK_HZ from Clk_In and counts BCD digits MM:SS.t from 00:00.0 to 59:59.9.
- Drives the enable of the existing clock-divider stage and feeds the display path.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 10, tick rate in Hz; one tick adds one tenth of a second.
- TICK_DIV, CLK_HZ/TICK_HZ, clock cycles per tick. Must be at least 2; benches override it with a small value.

Ports:
- Clk_In  in  1  system clock; every register updates on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start_Btn  in  1  single-cycle pulse, debounced upstream.
- Stop_Btn  in  1  single-cycle pulse.
- Clear_Btn  in  1  single-cycle pulse.
- Div_En  out  1  enable to the downstream divider; high only while RUNNING.
- Tick  out  1  one-cycle strobe on each counted tick.
- Tenths  out  4  BCD 0-9.
- Sec_Ones  out  4  BCD 0-9.
- Sec_Tens  out  4  BCD 0-5.
- Min_Ones  out  4  BCD 0-9.
- Min_Tens  out  4  BCD 0-5.
- State  out  2  IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.
- Expired  out  1  high while in EXPIRED.

Behaviour:
- Reset: a synchronous Rst (Rst high at a Clk_In edge) sets all of the following on that edge, regardless of state:
  - State=IDLE.
  - All digits 0.
  - Tick prescaler 0.
  - Tick=0, Div_En=0, Expired=0.
- Button priority when pulses coincide in one cycle: Clear > Stop > Start.
- FSM transitions (on the edge where the pulse is sampled):
  - IDLE: Start -> RUNNING. Stop and Clear are no-ops.
  - RUNNING: Stop -> PAUSED. Clear -> IDLE and zeroes digits and prescaler. Start is ignored.
  - PAUSED: Start -> RUNNING, resuming from the held prescaler value (phase preserved). Clear -> IDLE with zeroing. Stop is ignored.
  - EXPIRED: only Clear -> IDLE with zeroing. Start and Stop are ignored.
- Prescaler: width is ceil(log2(TICK_DIV)).
  - Increments only in RUNNING.
  - On reaching TICK_DIV-1 it wraps to 0 and Tick pulses high for exactly one cycle.
  - First tick after Start from IDLE occurs TICK_DIV cycles after the Start edge.
- Digit update on Tick (registered; new value visible the cycle after the Tick strobe edge):
  - Tenths 9->0 carries into Sec_Ones.
  - Sec_Ones 9->0 carries into Sec_Tens.
  - Sec_Tens 5->0 carries into Min_Ones.
  - Min_Ones 9->0 carries into Min_Tens.
  - Ripple carry is computed combinationally within one cycle.
- Expiry: a Tick while digits read 59:59.9:
  - Digits hold at 59:59.9 (no wrap).
  - State -> EXPIRED, Expired=1, Div_En=0.
  - That Tick strobe is still emitted.
- Stop and Tick in the same cycle: the tick is counted, then the FSM enters PAUSED with the prescaler at 0.
- Clear and Tick in the same cycle: Clear wins; digits go to 0 and the tick is discarded.
- Div_En is a registered decode of State==RUNNING, so it is aligned with State.
- Digit outputs are always legal BCD within the ranges listed under Ports.

Optional Feature:
- Macro: TIMER_LAP_HOLD_EN.
- When defined:
  - Adds input port Lap_Btn (1 bit, single-cycle pulse).
  - In RUNNING, Lap_Btn toggles a lap-hold flag.
  - While the flag is set, the five digit outputs show a snapshot latched at the first Lap_Btn pulse; the internal count keeps advancing.
  - The flag clears on Clear, on entry to EXPIRED, or on Rst.
  - Priority: Clear > Stop > Lap > Start.
- When undefined: no Lap_Btn port; digit outputs always show the live count.

Decomposition:
- Shared package timer_pkg holds:
  - the 2-bit state encodings (IDLE, RUNNING, PAUSED, EXPIRED);
  - the BCD digit limits (9 and 5) and the expiry value 59:59.9;
  - the default CLK_HZ and TICK_HZ.
- One sub-module, tick_prescaler:
  - inputs: Clk_In, Rst, Run, Zero;
  - output: Tick;
  - parameter: TICK_DIV;
  - holds its count when Run is low and zeroes it on Zero.
- FSM and BCD chain stay in timer_run_controller.

Test Plan:
- TICK_DIV=4. Rst, then Start at cycle 0 -> Div_En=1 the next cycle; Tick at cycles 4, 8, 12; Tenths = 1, 2, 3 after each.
- Run to 00:09.9 then one more Tick -> Tenths=0, Sec_Ones=1. At 00:59.9 plus one Tick -> Sec_Tens=0, Sec_Ones=0, Min_Ones=1.
- Stop 2 cycles after a Tick, wait 20 cycles, then Start -> no ticks while PAUSED; next Tick arrives 2 cycles after Start (phase preserved).
- Preload via a run to 59:59.8, then two Ticks -> 59:59.9, then EXPIRED with Expired=1 and Div_En=0. Digits hold; Start is ignored; Clear -> IDLE at 00:00.0.
- Start, Stop and Clear in the same cycle while RUNNING -> IDLE with zeroed digits. Rst asserted mid-run -> all outputs return to reset values on the next edge.
- With TIMER_LAP_HOLD_EN: Lap at 00:01.2, run 5 more Ticks -> display holds 00:01.2; second Lap -> live 00:01.7.
